// File: rtl/corner_tile_peak.sv
// ---------------------------------------------------------------------------
// corner_tile_peak
//
// Picks the strongest corner response in every 64x64 tile of the current
// 64-row band. At each band end the live per-tile bests are snapshotted into
// a shadow bank. A small drain FSM then walks that bank in tile order and
// pushes the qualifying peaks into a show-ahead feature FIFO.
//
// Ports
//   clk, rst      system clock, asynchronous active-high reset
//   pix_valid     pixin/col/row valid this cycle
//   pixin [7:0]   unsigned corner response
//   col   [12:0]  column of pixin, 0..IMG_W-1
//   row   [12:0]  row of pixin, 0..IMG_H-1
//   thresh [7:0]  minimum emitted score, latched at each snapshot
//   feat_valid    head feature word available
//   feat_ready    consumer accepts the head word when feat_valid && feat_ready
//   feat_col/row/score  head feature word {column, row, score}
//   busy          drain in progress
//   overrun       sticky: a band snapshot arrived while draining and was lost
// ---------------------------------------------------------------------------
module corner_tile_peak #(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_valid,
  input  logic [7:0]  pixin,
  input  logic [12:0] col,
  input  logic [12:0] row,
  input  logic [7:0]  thresh,
  output logic        feat_valid,
  input  logic        feat_ready,
  output logic [12:0] feat_col,
  output logic [12:0] feat_row,
  output logic [7:0]  feat_score,
  output logic        busy,
  output logic        overrun
);

  localparam int NT = IMG_W / 64;
  localparam int IW = (NT > 1) ? $clog2(NT) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  // Live bank: running best of each tile in the current band.
  logic [7:0]    live_score_q [NT];
  logic [7:0]    live_score_d [NT];
  logic [12:0]   live_col_q   [NT];
  logic [12:0]   live_col_d   [NT];
  logic [12:0]   live_row_q   [NT];
  logic [12:0]   live_row_d   [NT];
  logic [NT-1:0] live_hit_q, live_hit_d;

  // Shadow bank: frozen copy of the previous band, walked by the drain.
  logic [7:0]    sh_score_q [NT];
  logic [7:0]    sh_score_d [NT];
  logic [12:0]   sh_col_q   [NT];
  logic [12:0]   sh_col_d   [NT];
  logic [12:0]   sh_row_q   [NT];
  logic [12:0]   sh_row_d   [NT];
  logic [NT-1:0] sh_hit_q, sh_hit_d;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    thr_q, thr_d;
  logic          busy_q, busy_d;
  logic          overrun_q, overrun_d;

  // Feature FIFO. head_q is a registered copy of the oldest entry so the
  // outputs only move on a pop or on the first push into an empty FIFO.
  logic [33:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [33:0]   head_q, head_d;
  logic          fvalid_q, fvalid_d;

  logic          band_end;
  logic          qualify;
  logic          full;
  logic          push;
  logic          pop;
  logic [33:0]   push_data;

  // The last column of a row closes a band on every 64th row and on the
  // final image row, which may end a partial bottom band.
  assign band_end = pix_valid && (col == 13'(IMG_W - 1)) &&
                    ((row[5:0] == 6'd63) || (row == 13'(IMG_H - 1)));

  assign qualify   = sh_hit_q[idx_q] && (sh_score_q[idx_q] >= thr_q);
  // Full is judged on the registered count, before this cycle's pop.
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign pop       = fvalid_q && feat_ready;
  assign push_data = {sh_col_q[idx_q], sh_row_q[idx_q], sh_score_q[idx_q]};

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the block can leave a value unassigned and infer a latch.
    live_score_d = live_score_q;
    live_col_d   = live_col_q;
    live_row_d   = live_row_q;
    live_hit_d   = live_hit_q;
    sh_score_d   = sh_score_q;
    sh_col_d     = sh_col_q;
    sh_row_d     = sh_row_q;
    sh_hit_d     = sh_hit_q;
    state_d      = state_q;
    idx_d        = idx_q;
    thr_d        = thr_q;
    busy_d       = busy_q;
    overrun_d    = overrun_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    head_d       = head_q;
    push         = 1'b0;

    // Live update: strict greater-than keeps the earliest raster position
    // on ties; an empty tile takes whatever arrives first.
    for (int i = 0; i < NT; i++) begin
      if (pix_valid && (col[12:6] == 7'(i)) &&
          (!live_hit_q[i] || (pixin > live_score_q[i]))) begin
        live_score_d[i] = pixin;
        live_col_d[i]   = col;
        live_row_d[i]   = row;
        live_hit_d[i]   = 1'b1;
      end
    end

    // Snapshot takes the bank already merged with the band-end beat.
    if (band_end) begin
      if (state_q == S_IDLE) begin
        sh_score_d = live_score_d;
        sh_col_d   = live_col_d;
        sh_row_d   = live_row_d;
        sh_hit_d   = live_hit_d;
        thr_d      = thresh;
        state_d    = S_DRAIN;
        idx_d      = '0;
        busy_d     = 1'b1;
      end else begin
        overrun_d  = 1'b1;
      end
      live_hit_d = '0;
    end

    // Drain one shadow tile per cycle; a qualifying tile waits on a full FIFO.
    if (state_q == S_DRAIN) begin
      if (qualify && !full) begin
        push = 1'b1;
      end
      if (!qualify || !full) begin
        if (idx_q == IW'(NT - 1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          idx_d   = idx_q + IW'(1);
        end
      end
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d  = count_q + CW'(push) - CW'(pop);
    fvalid_d = (count_d != '0);

    // Head register: on a pop the next entry is either already stored or is
    // the word being pushed into a FIFO that held only the departing head.
    if (pop) begin
      if (count_q > CW'(1)) begin
        head_d = mem_q[rd_ptr_q + PW'(1)];
      end else if (push) begin
        head_d = push_data;
      end
    end else if (push && (count_q == '0)) begin
      head_d = push_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      thr_q     <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      live_hit_q <= '0;
      sh_hit_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      head_q    <= '0;
      fvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      thr_q     <= thr_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      live_hit_q <= live_hit_d;
      sh_hit_q  <= sh_hit_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      head_q    <= head_d;
      fvalid_q  <= fvalid_d;
    end
  end

  // NOTE: data arrays are left unreset; the hit bits and the FIFO count gate
  // every read, so stale contents are never observed after reset.
  always_ff @(posedge clk) begin
    live_score_q <= live_score_d;
    live_col_q   <= live_col_d;
    live_row_q   <= live_row_d;
    sh_score_q   <= sh_score_d;
    sh_col_q     <= sh_col_d;
    sh_row_q     <= sh_row_d;
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign feat_valid = fvalid_q;
  assign feat_col   = head_q[33:21];
  assign feat_row   = head_q[20:8];
  assign feat_score = head_q[7:0];
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_corner_tile_peak.sv
// ---------------------------------------------------------------------------
// tb_corner_tile_peak
//
// Directed bench for corner_tile_peak at IMG_W=640, IMG_H=480, FIFO_DEPTH=4.
// Expected features are queued when the band-end beat is driven; a negedge
// monitor pops and compares one entry per accepted handshake.
// ---------------------------------------------------------------------------
module tb_corner_tile_peak;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid;
  logic [7:0]  pixin;
  logic [12:0] col;
  logic [12:0] row;
  logic [7:0]  thresh;
  logic        feat_valid;
  logic        feat_ready;
  logic [12:0] feat_col;
  logic [12:0] feat_row;
  logic [7:0]  feat_score;
  logic        busy;
  logic        overrun;

  int tests = 0;
  int fails = 0;
  logic [33:0] sb [$];

  corner_tile_peak #(.IMG_W(640), .IMG_H(480), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_valid  (pix_valid),
    .pixin      (pixin),
    .col        (col),
    .row        (row),
    .thresh     (thresh),
    .feat_valid (feat_valid),
    .feat_ready (feat_ready),
    .feat_col   (feat_col),
    .feat_row   (feat_row),
    .feat_score (feat_score),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] fw(input int c, input int r, input int s);
    return {13'(c), 13'(r), 8'(s)};
  endfunction

  // Scoreboard monitor: the handshake seen at a negedge completes at the
  // following posedge, since inputs only change just after posedges.
  always @(negedge clk) begin
    if (!rst && feat_valid && feat_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_feature", 64'(sb.size()), 64'd1);
      end else begin
        check("sb_feature", 64'({feat_col, feat_row, feat_score}), 64'(sb.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One pixel beat, launched just after a posedge, accepted on the next one.
  task automatic beat(input int c, input int r, input int p);
    pix_valid = 1'b1;
    col       = 13'(c);
    row       = 13'(r);
    pixin     = 8'(p);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
  endtask

  // Called right after the band-end beat: counts busy negedges and records
  // the negedge (k-th after the snapshot edge) where feat_valid first rises.
  task automatic measure(output int nbusy, output int first_valid);
    nbusy       = 0;
    first_valid = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (first_valid == 0 && feat_valid) first_valid = k;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (k < 300 && (busy || feat_valid || sb.size() != 0)) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(k < 300), 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nb;
    int fv;

    rst        = 1'b1;
    pix_valid  = 1'b0;
    pixin      = '0;
    col        = '0;
    row        = '0;
    thresh     = 8'd10;
    feat_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_feat_valid", 64'(feat_valid), 64'd0);
    check("rst_feat_word", 64'({feat_col, feat_row, feat_score}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single peak in tile 2: pushed at T+3, so first seen at negedge 4.
    beat(130, 5, 200);
    sb.push_back(fw(130, 5, 200));
    beat(639, 63, 0);
    measure(nb, fv);
    check("single_busy_cycles", 64'(nb), 64'd10);
    check("single_first_valid", 64'(fv), 64'd4);
    wait_idle("single_drained");

    // Tie keeps (3,1); tile 1 at 9 is under thresh 10. Tile 0 pushes at T+1.
    beat(3, 1, 50);
    beat(9, 9, 50);
    beat(70, 2, 9);
    sb.push_back(fw(3, 1, 50));
    beat(639, 63, 0);
    measure(nb, fv);
    check("tie_busy_cycles", 64'(nb), 64'd10);
    check("tie_first_valid", 64'(fv), 64'd2);
    wait_idle("tie_drained");

    // A band-end position with pix_valid low must not start a drain.
    col = 13'd639;
    row = 13'd63;
    pixin = 8'd255;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("novalid_no_band_end", 64'(busy), 64'd0);
    @(posedge clk);
    #1;

    // Partial bottom band closes on the last image row.
    beat(70, 470, 90);
    sb.push_back(fw(70, 470, 90));
    beat(639, 479, 0);
    measure(nb, fv);
    check("bottom_busy_cycles", 64'(nb), 64'd10);
    check("bottom_first_valid", 64'(fv), 64'd3);
    wait_idle("bottom_drained");

    // Backpressure: all 10 tiles qualify, consumer stalled for 20 cycles.
    feat_ready = 1'b0;
    for (int t = 0; t < 10; t++) beat(t * 64 + 1, 10, 20 + t);
    for (int t = 0; t < 10; t++) sb.push_back(fw(t * 64 + 1, 10, 20 + t));
    beat(639, 63, 0);
    repeat (20) @(negedge clk);
    check("bp_stalled_busy", 64'(busy), 64'd1);
    check("bp_head_valid", 64'(feat_valid), 64'd1);
    check("bp_head_word", 64'({feat_col, feat_row, feat_score}), 64'(fw(1, 10, 20)));
    @(posedge clk);
    #1;
    feat_ready = 1'b1;
    wait_idle("bp_all_drained");

    // Overrun: a second band end lands while the drain is stalled.
    feat_ready = 1'b0;
    for (int t = 0; t < 10; t++) beat(t * 64 + 2, 20, 40 + t);
    for (int t = 0; t < 10; t++) sb.push_back(fw(t * 64 + 2, 20, 40 + t));
    beat(639, 63, 0);
    repeat (10) @(posedge clk);
    #1;
    check("ovr_before", 64'(overrun), 64'd0);
    beat(5, 70, 250);
    beat(639, 127, 0);
    @(negedge clk);
    check("ovr_set", 64'(overrun), 64'd1);
    check("ovr_still_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    feat_ready = 1'b1;
    wait_idle("ovr_first_band_drained");
    repeat (5) @(negedge clk);
    check("ovr_sticky", 64'(overrun), 64'd1);
    check("ovr_second_band_dropped", 64'(feat_valid), 64'd0);
    @(posedge clk);
    #1;

    // Reset mid-drain after 3 pushes (T+1..T+3), with a live hit pending.
    feat_ready = 1'b0;
    for (int t = 0; t < 10; t++) beat(t * 64 + 3, 30, 60 + t);
    beat(639, 63, 0);
    beat(400, 20, 99);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("mid_drain_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_feat_valid", 64'(feat_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_overrun", 64'(overrun), 64'd0);
    check("mid_rst_feat_word", 64'({feat_col, feat_row, feat_score}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    feat_ready = 1'b1;
    beat(200, 1, 77);
    sb.push_back(fw(200, 1, 77));
    beat(639, 63, 0);
    wait_idle("post_rst_drained");
    repeat (3) @(negedge clk);
    check("post_rst_quiet", 64'(feat_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
